// File: rtl/lin_comb_calc_v_pkg.sv
// rtl/lin_comb_calc_v_pkg.sv - shared state encoding and width helpers for the calculator blocks
package lin_comb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } lc_state_t;

    // ceil(log2(n)); 0 for n <= 1
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Accumulator width that cannot overflow for n_terms products of
    // an extended operand (width+1) and a signed coefficient.
    function automatic int calc_acc_w(input int width, input int coef_width, input int n_terms);
        return width + 1 + coef_width + clog2(n_terms);
    endfunction

    // Number of accumulator top bits that must all equal the output sign
    // bit for the value to fit in out_w signed bits.
    function automatic int sat_chk_w(input int acc_w, input int out_w);
        return (acc_w > out_w) ? (acc_w - out_w + 1) : 1;
    endfunction

endpackage

// File: rtl/lin_comb_calc_v_if.sv
// rtl/lin_comb_calc_v_if.sv - operand/result handshake bundle for lin_comb_calc_v
interface lin_comb_calc_v_if #(
    parameter int WIDTH      = 4,
    parameter int N_TERMS    = 3,
    parameter int COEF_WIDTH = 4,
    parameter int OUT_WIDTH  = 8
);

    logic [N_TERMS*WIDTH-1:0]      i_x;
    logic [N_TERMS*COEF_WIDTH-1:0] i_coef;
    logic                          i_valid;
    logic                          o_ready;
    logic [OUT_WIDTH-1:0]          o_f;
    logic                          o_ovf;
    logic                          o_valid;
    logic                          i_ready;

    // Producer/consumer side
    modport master (
        output i_x,
        output i_coef,
        output i_valid,
        output i_ready,
        input  o_ready,
        input  o_f,
        input  o_ovf,
        input  o_valid
    );

    // Calculator side
    modport slave (
        input  i_x,
        input  i_coef,
        input  i_valid,
        input  i_ready,
        output o_ready,
        output o_f,
        output o_ovf,
        output o_valid
    );

endinterface

// File: rtl/lin_comb_calc_v_mac.sv
// rtl/lin_comb_calc_v_mac.sv - one multiply-accumulate step: acc + ext(x)*c
module lin_comb_mac_v #(
    parameter int WIDTH      = 4,
    parameter int COEF_WIDTH = 4,
    parameter int ACC_W      = 11,
    parameter int SIGNED_IN  = 0
) (
    input  logic [WIDTH-1:0]             i_x,
    input  logic signed [COEF_WIDTH-1:0] i_coef,
    input  logic signed [ACC_W-1:0]      i_acc,
    output logic signed [ACC_W-1:0]      o_acc
);

    localparam int PROD_W = WIDTH + 1 + COEF_WIDTH;

    logic signed [WIDTH:0]    w_x_ext;
    logic signed [PROD_W-1:0] w_prod;

    // One extra bit lets unsigned operands be treated as non-negative signed values
    assign w_x_ext = (SIGNED_IN != 0) ? {i_x[WIDTH-1], i_x} : {1'b0, i_x};

    // Both factors are sign-extended to the full product width before multiplying
    assign w_prod = PROD_W'(w_x_ext) * PROD_W'(i_coef);

    assign o_acc = i_acc + ACC_W'(w_prod);

endmodule

// File: rtl/lin_comb_calc_v.sv
// rtl/lin_comb_calc_v.sv - sequential linear-combination calculator F = sum(c_k * x_k)
module lin_comb_calc_v
    import lin_comb_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int N_TERMS    = 3,
    parameter int COEF_WIDTH = 4,
    parameter int OUT_WIDTH  = 8,
    parameter int SIGNED_IN  = 0,
    parameter int SAT        = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    lin_comb_calc_v_if.slave bus
);

    localparam int ACC_W = calc_acc_w(WIDTH, COEF_WIDTH, N_TERMS);
    localparam int K_W   = (N_TERMS > 1) ? clog2(N_TERMS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_TERMS - 1);

    lc_state_t                     r_state;
    lc_state_t                     w_state_nxt;
    logic [N_TERMS*WIDTH-1:0]      r_x;
    logic [N_TERMS*COEF_WIDTH-1:0] r_coef;
    logic signed [ACC_W-1:0]       r_acc;
    logic signed [ACC_W-1:0]       w_acc_nxt;
    logic [K_W-1:0]                r_k;
    logic [OUT_WIDTH-1:0]          r_f;
    logic                          r_ovf;
    logic [OUT_WIDTH-1:0]          w_f;
    logic [OUT_WIDTH-1:0]          w_wrap;
    logic [OUT_WIDTH-1:0]          w_sat;
    logic                          w_ovf;
    logic                          w_accept;
    logic                          w_last;

    assign w_accept = (r_state == IDLE) && bus.i_valid;
    assign w_last   = (r_state == ACCUM) && (r_k == K_LAST);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs, decoded from the state register only
    always_comb begin
        w_state_nxt = r_state;
        bus.o_ready = 1'b0;
        bus.o_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                bus.o_valid = 1'b1;
                if (bus.i_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and accumulation; operands shift down so term k is always in the low slot
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x    <= '0;
            r_coef <= '0;
            r_acc  <= '0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_x    <= bus.i_x;
            r_coef <= bus.i_coef;
            r_acc  <= '0;
            r_k    <= '0;
        end else if (r_state == ACCUM) begin
            r_x    <= r_x >> WIDTH;
            r_coef <= r_coef >> COEF_WIDTH;
            r_acc  <= w_acc_nxt;
            r_k    <= r_k + K_W'(1);
        end
    end

    lin_comb_mac_v #(
        .WIDTH      (WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_W      (ACC_W),
        .SIGNED_IN  (SIGNED_IN)
    ) u_mac (
        .i_x    (r_x[WIDTH-1:0]),
        .i_coef (r_coef[COEF_WIDTH-1:0]),
        .i_acc  (r_acc),
        .o_acc  (w_acc_nxt)
    );

    // Range check on the final sum: it fits iff the bits from the output
    // sign bit upward are all equal.
    generate
        if (ACC_W > OUT_WIDTH) begin : g_narrow
            localparam int CHK_W = sat_chk_w(ACC_W, OUT_WIDTH);
            logic [CHK_W-1:0] w_top;
            assign w_top  = w_acc_nxt[ACC_W-1 -: CHK_W];
            assign w_ovf  = !((&w_top) || !(|w_top));
            assign w_wrap = w_acc_nxt[OUT_WIDTH-1:0];
        end else begin : g_wide
            assign w_ovf  = 1'b0;
            assign w_wrap = OUT_WIDTH'(w_acc_nxt);
        end
    endgenerate

    assign w_sat = w_acc_nxt[ACC_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    assign w_f   = ((SAT != 0) && w_ovf) ? w_sat : w_wrap;

    // Result register, loaded on the last accumulation cycle and held until the next result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_f   <= '0;
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_f   <= w_f;
            r_ovf <= w_ovf;
        end
    end

    assign bus.o_f   = r_f;
    assign bus.o_ovf = r_ovf;

endmodule

// File: tb/tb_lin_comb_calc_v.sv
// tb/tb_lin_comb_calc_v.sv - directed self-checking bench for lin_comb_calc_v
module tb_lin_comb_calc_v;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    lin_comb_calc_v_if #(.WIDTH(4), .N_TERMS(3), .COEF_WIDTH(4), .OUT_WIDTH(8)) if0 ();
    lin_comb_calc_v_if #(.WIDTH(4), .N_TERMS(3), .COEF_WIDTH(4), .OUT_WIDTH(8)) if1 ();
    lin_comb_calc_v_if #(.WIDTH(4), .N_TERMS(3), .COEF_WIDTH(4), .OUT_WIDTH(8)) if2 ();
    lin_comb_calc_v_if #(.WIDTH(8), .N_TERMS(5), .COEF_WIDTH(4), .OUT_WIDTH(8)) if3 ();

    lin_comb_calc_v #(.WIDTH(4), .N_TERMS(3), .COEF_WIDTH(4), .OUT_WIDTH(8), .SIGNED_IN(0), .SAT(0))
        u_dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    lin_comb_calc_v #(.WIDTH(4), .N_TERMS(3), .COEF_WIDTH(4), .OUT_WIDTH(8), .SIGNED_IN(0), .SAT(1))
        u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    lin_comb_calc_v #(.WIDTH(4), .N_TERMS(3), .COEF_WIDTH(4), .OUT_WIDTH(8), .SIGNED_IN(1), .SAT(0))
        u_dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));
    lin_comb_calc_v #(.WIDTH(8), .N_TERMS(5), .COEF_WIDTH(4), .OUT_WIDTH(8), .SIGNED_IN(1), .SAT(1))
        u_dut3 (.i_clk(clk), .i_rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [11:0] x, input logic [11:0] c, input logic v, input logic rdy);
        if0.i_x = x; if0.i_coef = c; if0.i_valid = v; if0.i_ready = rdy;
        if1.i_x = x; if1.i_coef = c; if1.i_valid = v; if1.i_ready = rdy;
        if2.i_x = x; if2.i_coef = c; if2.i_valid = v; if2.i_ready = rdy;
    endtask

    // One transaction on the three 3-term DUTs; optional 10-cycle backpressure in DONE
    task automatic run3(input string tag, input logic [11:0] x, input logic [11:0] c,
                        input logic [7:0] f0, input logic ov0,
                        input logic [7:0] f1, input logic ov1,
                        input logic [7:0] f2, input logic ov2,
                        input bit bp);
        int lat;
        logic [7:0] f_hold;
        @(negedge clk);
        check({tag, ":ready_idle"}, if0.o_ready, 1'b1);
        set_in(x, c, 1'b1, !bp);
        @(posedge clk);
        @(negedge clk);
        set_in(~x, ~c, 1'b0, !bp);
        lat = 0;
        while (!if0.o_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ":latency"}, lat, 3);
        check({tag, ":f0"}, if0.o_f, f0);
        check({tag, ":ovf0"}, if0.o_ovf, ov0);
        check({tag, ":f1"}, if1.o_f, f1);
        check({tag, ":ovf1"}, if1.o_ovf, ov1);
        check({tag, ":f2"}, if2.o_f, f2);
        check({tag, ":ovf2"}, if2.o_ovf, ov2);
        check({tag, ":ready_done"}, if0.o_ready, 1'b0);
        check({tag, ":valid2"}, if2.o_valid, 1'b1);
        if (bp) begin
            f_hold = if0.o_f;
            for (int i = 0; i < 10; i++) begin
                if0.i_valid = ~if0.i_valid;
                if0.i_x = 12'($urandom);
                @(posedge clk);
                @(negedge clk);
                check({tag, ":bp_f"}, if0.o_f, f_hold);
                check({tag, ":bp_ovf"}, if0.o_ovf, ov0);
                check({tag, ":bp_ready"}, if0.o_ready, 1'b0);
                check({tag, ":bp_valid"}, if0.o_valid, 1'b1);
            end
            set_in(x, c, 1'b0, 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, ":ready_after"}, if0.o_ready, 1'b1);
        check({tag, ":valid_after"}, if0.o_valid, 1'b0);
        check({tag, ":ready_after1"}, if1.o_ready, 1'b1);
    endtask

    // Five-term signed/saturating DUT against a small golden sum
    task automatic run_dut3(input string tag, input logic [39:0] x, input logic [19:0] c);
        int s;
        int lat;
        logic [7:0] exp_f;
        logic exp_ovf;
        s = 0;
        for (int k = 0; k < 5; k++) begin
            s += int'($signed(x[k*8 +: 8])) * int'($signed(c[k*4 +: 4]));
        end
        exp_ovf = (s > 127) || (s < -128);
        exp_f   = exp_ovf ? ((s < 0) ? 8'h80 : 8'h7F) : 8'(s);
        @(negedge clk);
        if3.i_x = x; if3.i_coef = c; if3.i_valid = 1'b1; if3.i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if3.i_valid = 1'b0;
        lat = 0;
        while (!if3.o_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ":latency"}, lat, 5);
        check({tag, ":f"}, if3.o_f, exp_f);
        check({tag, ":ovf"}, if3.o_ovf, exp_ovf);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        set_in(12'h000, 12'h000, 1'b0, 1'b1);
        if3.i_x = '0; if3.i_coef = '0; if3.i_valid = 1'b0; if3.i_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst:ready", if0.o_ready, 1'b1);
        check("rst:valid", if0.o_valid, 1'b0);
        check("rst:f", if0.o_f, 8'h00);
        check("rst:ovf", if0.o_ovf, 1'b0);
        check("rst:ready3", if3.o_ready, 1'b1);
        rst = 1'b0;

        // coef = (7,-3,6) packed as {6,-3,7}
        run3("v_213", 12'h312, 12'h6D7, 8'h1D, 1'b0, 8'h1D, 1'b0, 8'h1D, 1'b0, 1'b0);
        run3("v_0f0", 12'h0F0, 12'h6D7, 8'hD3, 1'b0, 8'hD3, 1'b0, 8'h03, 1'b0, 1'b0);
        run3("v_f0f", 12'hF0F, 12'h6D7, 8'hC3, 1'b1, 8'h7F, 1'b1, 8'hF3, 1'b0, 1'b0);
        run3("v_f87", 12'h78F, 12'h6D7, 8'h7B, 1'b0, 8'h7B, 1'b0, 8'h3B, 1'b0, 1'b0);
        run3("v_neg", 12'hFFF, 12'h888, 8'h98, 1'b1, 8'h80, 1'b1, 8'h18, 1'b0, 1'b0);
        run3("v_pos", 12'h777, 12'h777, 8'h93, 1'b1, 8'h7F, 1'b1, 8'h93, 1'b1, 1'b0);
        run3("bp", 12'hF0F, 12'h6D7, 8'hC3, 1'b1, 8'h7F, 1'b1, 8'hF3, 1'b0, 1'b1);

        // Reset between edges 1 and 2 after accept
        @(negedge clk);
        set_in(12'h78F, 12'h6D7, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_in(12'h78F, 12'h6D7, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid:ready", if0.o_ready, 1'b1);
        check("rst_mid:valid", if0.o_valid, 1'b0);
        check("rst_mid:f", if0.o_f, 8'h00);
        check("rst_mid:ovf", if0.o_ovf, 1'b0);
        check("rst_mid:f1", if1.o_f, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        run3("after_rst", 12'h312, 12'h6D7, 8'h1D, 1'b0, 8'h1D, 1'b0, 8'h1D, 1'b0, 1'b0);

        // Five-term DUT: a fixed saturating case, then random vectors
        run_dut3("d3_max", {5{8'h80}}, {5{4'h8}});
        run_dut3("d3_min", {5{8'h7F}}, {5{4'h8}});
        for (int i = 0; i < 8; i++) begin
            run_dut3("d3_rand", {8'($urandom), 32'($urandom)}, 20'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lin_comb_calc_v.md
# lin_comb_calc_v

Sequential, parametrised linear-combination calculator computing F = Σ c_k·x_k over N_TERMS operands with run-time signed coefficients. It generalises the fixed 7X−3Y+6Z datapath to arbitrary widths, term counts, coefficients and operand signedness, adding a valid/ready handshake and a saturate/wrap output mode. It is used as an arithmetic stage between operand-capture logic and result consumers in the calculator datapath.

## Interface
- WIDTH, 4: operand width per term, in bits.
- N_TERMS, 3: number of terms, ≥1.
- COEF_WIDTH, 4: signed coefficient width.
- OUT_WIDTH, 8: result width, two's complement.
- SIGNED_IN, 0: 0 = operands unsigned, 1 = operands two's complement.
- SAT, 0: 0 = result wraps mod 2^OUT_WIDTH, 1 = result saturates.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_x  in  N_TERMS*WIDTH  operands; term k occupies [k*WIDTH +: WIDTH].
- i_coef  in  N_TERMS*COEF_WIDTH  signed coefficients; term k occupies [k*COEF_WIDTH +: COEF_WIDTH].
- i_valid  in  1  input transaction offered.
- o_ready  out  1  block can accept an input transaction.
- o_f  out  OUT_WIDTH  result, two's complement.
- o_ovf  out  1  exact sum lies outside the OUT_WIDTH signed range.
- o_valid  out  1  o_f and o_ovf are valid.
- i_ready  in  1  consumer takes the result.

## Operation
- FSM states: IDLE, ACCUM, DONE.
  - o_ready = (state==IDLE).
  - o_valid = (state==DONE).
- IDLE: on i_valid && o_ready:
  - latch i_x and i_coef into internal registers;
  - clear the accumulator and set the term index k=0;
  - go to ACCUM.
- ACCUM: each cycle, acc += sext(x_k)·c_k, then k++.
  - When the cycle uses k==N_TERMS−1, go to DONE and register o_f and o_ovf from the final accumulator.
- DONE: hold o_f and o_ovf stable. On i_ready, go to IDLE.
  - i_valid is ignored in DONE and ACCUM.
  - Input changes after the accept edge have no effect.
- Operand extension:
  - SIGNED_IN=0: zero-extend x_k to WIDTH+1.
  - SIGNED_IN=1: sign-extend x_k to WIDTH+1.
- Arithmetic width:
  - Accumulator ACC_W = WIDTH+1+COEF_WIDTH+clog2(N_TERMS), signed.
  - The accumulator never overflows internally.
- Output overflow:
  - o_ovf = 1 iff acc < −2^(OUT_WIDTH−1) or acc > 2^(OUT_WIDTH−1)−1.
  - SAT=0: o_f = acc[OUT_WIDTH−1:0].
  - SAT=1 with overflow: o_f = max positive or min negative, according to the sign of acc.
- Asynchronous reset, asserted at any time (including mid-ACCUM or DONE):
  - state = IDLE; the in-flight transaction is discarded;
  - accumulator, k, o_f and o_ovf clear to 0.

## Timing
- Reset values:
  - o_ready=1 (IDLE);
  - o_valid=0, o_f=0, o_ovf=0.
- Latency: o_valid is high after the N_TERMS-th rising edge following the accepting edge. With N_TERMS=3: accept at edge 0, o_valid=1 after edge 3.
- Result handoff: the result is consumed on the edge where o_valid && i_ready. o_ready=1 after that edge.
- Throughput: one transaction per N_TERMS+2 cycles with i_ready held high. Back-to-back accept in DONE is not supported.
- Outputs are registered. o_ready and o_valid are decoded from the state register only, with no combinational path from i_valid or i_ready.

## Structure
- Shared package lin_comb_pkg holds:
  - the state encoding constants (IDLE/ACCUM/DONE);
  - a clog2 function;
  - the ACC_W and saturation-limit width helpers, reused by later calculator blocks.
- One sub-module, lin_comb_mac_v: a combinational slice taking one extended operand, one coefficient and the accumulator, producing the next accumulator value. It is parametrised by WIDTH, COEF_WIDTH, ACC_W and SIGNED_IN.
- The top level holds the FSM, operand and coefficient registers, the term index, and the output saturate/wrap logic.

## Test plan
- Default parameters, coef=(7,−3,6), x=(2,1,3), i_ready=1 → o_f=0x1D (29), o_ovf=0, o_valid rises 3 edges after accept, o_ready=1 one edge later.
- coef=(7,−3,6), x=(0,15,0) → o_f=0xD3 (−45), o_ovf=0.
- coef=(7,−3,6), x=(15,0,15) (195):
  - SAT=0 → o_f=0xC3, o_ovf=1;
  - SAT=1 → o_f=0x7F, o_ovf=1.
- Backpressure: i_ready=0 for 10 cycles in DONE while i_valid toggles and i_x changes → o_f and o_ovf stable, o_ready=0, no new accept; release i_ready → IDLE next edge.
- Reset mid-ACCUM (asserted between edges 1 and 2 after accept) → o_valid=0, o_f=0, o_ovf=0, o_ready=1 immediately. A following transaction x=(2,1,3) still yields 0x1D.
- SIGNED_IN=1, coef=(7,−3,6), x=(−1,−8,7) → 59, o_f=0x3B, o_ovf=0. With N_TERMS=5 and WIDTH=8, random vectors match the golden model Σc_k·x_k.
